// File: rtl/cache_set_controller.sv
// Per-set pairwise-LRU replacement and miss sequencer for a 4-way set-associative cache.
// Optional PERF_COUNT_EN adds saturating hit/miss/writeback counters.
module cache_set_controller #(
    parameter int SETS     = 16,
    parameter int SET_BITS = 4
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                ReqValid,
    output logic                ReqReady,
    input  logic [SET_BITS-1:0] ReqSet,
    input  logic [3:0]          ReqHit,
    input  logic                ReqWrite,
    output logic                WbReq,
    output logic [1:0]          WbWay,
    input  logic                WbAck,
    output logic                FillReq,
    output logic [1:0]          FillWay,
    input  logic                FillAck,
    output logic                RespValid,
    output logic [1:0]          RespWay,
    output logic                RespMiss
`ifdef PERF_COUNT_EN
    ,
    output logic [15:0]         HitCount,
    output logic [15:0]         MissCount,
    output logic [15:0]         WbCount
`endif
);

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, RESP} state_t;

    state_t              state;
    logic [5:0]          lru        [SETS];
    logic [3:0]          valid_bits [SETS];
    logic [3:0]          dirty_bits [SETS];
    logic [SET_BITS-1:0] req_set;
    logic [3:0]          req_hit;
    logic                req_write;
    logic [1:0]          victim;

    logic [5:0]          cur_lru;
    logic [3:0]          cur_valid;
    logic [3:0]          cur_dirty;
    logic [1:0]          hit_way;
    logic [1:0]          victim_c;

    // Bit order: pairs (0,1),(0,2),(0,3),(1,2),(1,3),(2,3); 1 = lower way more recent.
    function automatic logic [5:0] lru_touch(input logic [5:0] s, input logic [1:0] w);
        logic [5:0] n;
        n = s;
        case (w)
            2'd0: begin n[0] = 1'b1; n[1] = 1'b1; n[2] = 1'b1; end
            2'd1: begin n[0] = 1'b0; n[3] = 1'b1; n[4] = 1'b1; end
            2'd2: begin n[1] = 1'b0; n[3] = 1'b0; n[5] = 1'b1; end
            default: begin n[2] = 1'b0; n[4] = 1'b0; n[5] = 1'b0; end
        endcase
        return n;
    endfunction

    function automatic logic [1:0] lru_victim(input logic [5:0] s);
        if ({s[0], s[1], s[2]} == 3'b000)      return 2'd0;
        else if ({s[0], s[3], s[4]} == 3'b100) return 2'd1;
        else if ({s[1], s[3], s[5]} == 3'b110) return 2'd2;
        else                                   return 2'd3;
    endfunction

    always_comb begin
        cur_lru   = lru[req_set];
        cur_valid = valid_bits[req_set];
        cur_dirty = dirty_bits[req_set];
        hit_way   = 2'd3;
        if (req_hit[0])      hit_way = 2'd0;
        else if (req_hit[1]) hit_way = 2'd1;
        else if (req_hit[2]) hit_way = 2'd2;
        victim_c = lru_victim(cur_lru);
        if (!cur_valid[0])      victim_c = 2'd0;
        else if (!cur_valid[1]) victim_c = 2'd1;
        else if (!cur_valid[2]) victim_c = 2'd2;
        else if (!cur_valid[3]) victim_c = 2'd3;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            ReqReady  <= 1'b1;
            WbReq     <= 1'b0;
            WbWay     <= 2'd0;
            FillReq   <= 1'b0;
            FillWay   <= 2'd0;
            RespValid <= 1'b0;
            RespWay   <= 2'd0;
            RespMiss  <= 1'b0;
            req_set   <= '0;
            req_hit   <= '0;
            req_write <= 1'b0;
            victim    <= 2'd0;
            for (int i = 0; i < SETS; i++) begin
                lru[i]        <= '0;
                valid_bits[i] <= '0;
                dirty_bits[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (ReqValid && ReqReady) begin
                        req_set   <= ReqSet;
                        req_hit   <= ReqHit;
                        req_write <= ReqWrite;
                        ReqReady  <= 1'b0;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (req_hit != 4'b0000) begin
                        lru[req_set] <= lru_touch(cur_lru, hit_way);
                        if (req_write) dirty_bits[req_set][hit_way] <= 1'b1;
                        RespWay   <= hit_way;
                        RespMiss  <= 1'b0;
                        RespValid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        victim <= victim_c;
                        if (cur_valid[victim_c] && cur_dirty[victim_c]) begin
                            WbReq <= 1'b1;
                            WbWay <= victim_c;
                            state <= WB;
                        end else begin
                            FillReq <= 1'b1;
                            FillWay <= victim_c;
                            state   <= FILL;
                        end
                    end
                end
                WB: begin
                    if (WbAck) begin
                        WbReq   <= 1'b0;
                        FillReq <= 1'b1;
                        FillWay <= victim;
                        state   <= FILL;
                    end
                end
                FILL: begin
                    if (FillAck) begin
                        FillReq                     <= 1'b0;
                        valid_bits[req_set][victim] <= 1'b1;
                        dirty_bits[req_set][victim] <= req_write;
                        lru[req_set]                <= lru_touch(cur_lru, victim);
                        RespWay                     <= victim;
                        RespMiss                    <= 1'b1;
                        RespValid                   <= 1'b1;
                        state                       <= RESP;
                    end
                end
                RESP: begin
                    RespValid <= 1'b0;
                    ReqReady  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PERF_COUNT_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            HitCount  <= '0;
            MissCount <= '0;
            WbCount   <= '0;
        end else begin
            if (state == RESP && !RespMiss && HitCount != 16'hFFFF) HitCount <= HitCount + 16'd1;
            if (state == RESP && RespMiss && MissCount != 16'hFFFF) MissCount <= MissCount + 16'd1;
            if (state == WB && WbAck && WbCount != 16'hFFFF) WbCount <= WbCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_set_controller.sv
// Self-checking bench for cache_set_controller: directed scenarios plus randomized traffic
// checked against a recency-list reference model.
module tb_cache_set_controller;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       ReqValid;
    logic       ReqReady;
    logic [3:0] ReqSet;
    logic [3:0] ReqHit;
    logic       ReqWrite;
    logic       WbReq;
    logic [1:0] WbWay;
    logic       WbAck;
    logic       FillReq;
    logic [1:0] FillWay;
    logic       FillAck;
    logic       RespValid;
    logic [1:0] RespWay;
    logic       RespMiss;
`ifdef PERF_COUNT_EN
    logic [15:0] HitCount, MissCount, WbCount;
`endif

    cache_set_controller #(.SETS(16), .SET_BITS(4)) dut (
        .Clock(Clock), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqSet(ReqSet), .ReqHit(ReqHit), .ReqWrite(ReqWrite),
        .WbReq(WbReq), .WbWay(WbWay), .WbAck(WbAck),
        .FillReq(FillReq), .FillWay(FillWay), .FillAck(FillAck),
        .RespValid(RespValid), .RespWay(RespWay), .RespMiss(RespMiss)
`ifdef PERF_COUNT_EN
        , .HitCount(HitCount), .MissCount(MissCount), .WbCount(WbCount)
`endif
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    // Reference model: per set an MRU-first recency list plus valid/dirty flags.
    int rec    [16][4];
    bit mvalid [16][4];
    bit mdirty [16][4];
    int mhit, mmiss, mwb;

    typedef struct packed {
        int way; int miss; int wb; int wbway; int wbcyc; int fillway; int fillcyc;
        int first_fill; int last_wb; int lat; int rdy_err; int to;
    } obs_t;

    function automatic void model_reset();
        for (int s = 0; s < 16; s++)
            for (int k = 0; k < 4; k++) begin
                rec[s][k] = 3 - k;
                mvalid[s][k] = 1'b0;
                mdirty[s][k] = 1'b0;
            end
        mhit = 0; mmiss = 0; mwb = 0;
    endfunction

    function automatic void model_touch(input int s, input int w);
        int p;
        p = 0;
        for (int k = 0; k < 4; k++) if (rec[s][k] == w) p = k;
        for (int k = p; k > 0; k--) rec[s][k] = rec[s][k-1];
        rec[s][0] = w;
    endfunction

    function automatic void model_access(input int s, input logic [3:0] hit, input bit wr,
                                         output int way, output int miss, output int wb);
        way = -1; wb = 0;
        if (hit != 4'b0) begin
            for (int k = 3; k >= 0; k--) if (hit[k]) way = k;
            miss = 0;
            if (wr) mdirty[s][way] = 1'b1;
            mhit++;
        end else begin
            for (int k = 3; k >= 0; k--) if (!mvalid[s][k]) way = k;
            if (way < 0) way = rec[s][3];
            wb = (mvalid[s][way] && mdirty[s][way]) ? 1 : 0;
            mvalid[s][way] = 1'b1;
            mdirty[s][way] = wr;
            miss = 1;
            mmiss++;
            if (wb != 0) mwb++;
        end
        model_touch(s, way);
    endfunction

    task automatic run_txn(input int s, input logic [3:0] hit, input bit wr, input int wb_dly,
                           input int fill_dly, input bit stray, output obs_t r);
        int cyc, wbc, fc;
        bit got;
        r = '0;
        r.first_fill = -1; r.last_wb = -1;
        wbc = 0; fc = 0; got = 0;
        cyc = 0;
        @(negedge Clock);
        while (!ReqReady && cyc < 50) begin @(negedge Clock); cyc++; end
        if (!ReqReady) begin r.to = 1; return; end
        ReqValid = 1'b1; ReqSet = 4'(s); ReqHit = hit; ReqWrite = wr;
        @(posedge Clock);
        #1;
        ReqValid = 1'b0; ReqSet = 4'($urandom); ReqHit = 4'($urandom); ReqWrite = 1'($urandom);
        cyc = 0;
        while (!got && cyc < 200) begin
            @(negedge Clock);
            cyc++;
            if (ReqReady) r.rdy_err = 1;
            if (WbReq) begin r.wb = 1; r.wbway = WbWay; r.wbcyc++; r.last_wb = cyc; wbc++; end
            if (FillReq) begin
                r.fillway = FillWay; r.fillcyc++; fc++;
                if (r.first_fill < 0) r.first_fill = cyc;
            end
            WbAck   = WbReq && (wbc > wb_dly);
            FillAck = (FillReq && (fc > fill_dly)) || (stray && WbReq);
            if (RespValid) begin r.way = RespWay; r.miss = RespMiss; r.lat = cyc; got = 1; end
        end
        if (!got) r.to = 1;
        WbAck = 1'b0; FillAck = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        Reset = 1'b1; ReqValid = 1'b0; ReqSet = '0; ReqHit = '0; ReqWrite = 1'b0;
        WbAck = 1'b0; FillAck = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        total++;
        if (ReqReady !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ReqReady); end
        total++;
        if ({WbReq, FillReq, RespValid, RespMiss} !== 4'b0000) begin
            bad++; $display("FAIL reset_strobes: got %b want 0000", {WbReq, FillReq, RespValid, RespMiss});
        end
        total++;
        if ({WbWay, FillWay, RespWay} !== 6'b0) begin
            bad++; $display("FAIL reset_ways: got %b want 000000", {WbWay, FillWay, RespWay});
        end
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic test_fill_set3();
        obs_t r; int ew, em, ewb;
        for (int i = 0; i < 4; i++) begin
            model_access(3, 4'b0, 1'b0, ew, em, ewb);
            run_txn(3, 4'b0, 1'b0, 0, 1, 1'b0, r);
            total++;
            if (r.to != 0) begin bad++; $display("FAIL fill3_timeout: got %0d want 0", r.to); end
            total++;
            if (r.fillway != ew) begin bad++; $display("FAIL fill3_fillway: got %0d want %0d", r.fillway, ew); end
            total++;
            if (r.wb != 0) begin bad++; $display("FAIL fill3_nowb: got %0d want 0", r.wb); end
            total++;
            if (r.miss != 1 || r.way != ew) begin
                bad++; $display("FAIL fill3_resp: got way=%0d miss=%0d want way=%0d miss=1", r.way, r.miss, ew);
            end
            total++;
            if (r.fillcyc != 2) begin bad++; $display("FAIL fill3_fillcyc: got %0d want 2", r.fillcyc); end
        end
    endtask

    task automatic test_hit_then_miss();
        obs_t r; int ew, em, ewb;
        model_access(3, 4'b0100, 1'b0, ew, em, ewb);
        run_txn(3, 4'b0100, 1'b0, 0, 0, 1'b0, r);
        total++;
        if (r.way != ew || r.miss != 0) begin
            bad++; $display("FAIL hit2_resp: got way=%0d miss=%0d want way=%0d miss=0", r.way, r.miss, ew);
        end
        total++;
        if (r.lat != 2) begin bad++; $display("FAIL hit2_latency: got %0d want 2", r.lat); end
        model_access(3, 4'b0, 1'b0, ew, em, ewb);
        run_txn(3, 4'b0, 1'b0, 0, 0, 1'b0, r);
        total++;
        if (r.way != ew || r.miss != 1 || r.fillway != ew) begin
            bad++; $display("FAIL miss_lru_victim: got way=%0d fill=%0d want %0d", r.way, r.fillway, ew);
        end
    endtask

    task automatic test_writeback();
        obs_t r; int ew, em, ewb;
        logic [3:0] seq [4];
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            model_access(3, seq[i], (i == 0), ew, em, ewb);
            run_txn(3, seq[i], (i == 0), 0, 0, 1'b0, r);
            total++;
            if (r.way != ew || r.miss != 0) begin
                bad++; $display("FAIL wb_prep_hit: got way=%0d miss=%0d want way=%0d miss=0", r.way, r.miss, ew);
            end
        end
        model_access(3, 4'b0, 1'b0, ew, em, ewb);
        run_txn(3, 4'b0, 1'b0, 1, 0, 1'b0, r);
        total++;
        if (r.wb != ewb || r.wbway != ew) begin
            bad++; $display("FAIL wb_req: got wb=%0d way=%0d want wb=%0d way=%0d", r.wb, r.wbway, ewb, ew);
        end
        total++;
        if (r.first_fill <= r.last_wb) begin
            bad++; $display("FAIL wb_fill_order: got fill_at=%0d wb_end=%0d want fill after wb", r.first_fill, r.last_wb);
        end
        total++;
        if (r.way != ew || r.miss != 1) begin
            bad++; $display("FAIL wb_resp: got way=%0d miss=%0d want way=%0d miss=1", r.way, r.miss, ew);
        end
    endtask

    task automatic test_wb_delay();
        obs_t r; int ew, em, ewb;
        for (int i = 0; i < 4; i++) begin
            model_access(5, 4'b0, 1'b1, ew, em, ewb);
            run_txn(5, 4'b0, 1'b1, 0, 0, 1'b0, r);
            total++;
            if (r.way != ew) begin bad++; $display("FAIL wbd_prep: got way=%0d want %0d", r.way, ew); end
        end
        model_access(5, 4'b0, 1'b0, ew, em, ewb);
        run_txn(5, 4'b0, 1'b0, 5, 2, 1'b1, r);
        total++;
        if (r.wb != 1 || r.wbcyc != 6) begin
            bad++; $display("FAIL wbd_hold: got wb=%0d cycles=%0d want wb=1 cycles=6", r.wb, r.wbcyc);
        end
        total++;
        if (r.rdy_err != 0) begin bad++; $display("FAIL wbd_ready_low: got %0d want 0", r.rdy_err); end
        total++;
        if (r.first_fill <= r.last_wb || r.fillcyc != 3) begin
            bad++; $display("FAIL wbd_stray_ack: got fill_at=%0d wb_end=%0d fillcyc=%0d want after wb, 3",
                            r.first_fill, r.last_wb, r.fillcyc);
        end
        total++;
        if (r.way != ew || r.miss != 1) begin
            bad++; $display("FAIL wbd_resp: got way=%0d miss=%0d want way=%0d miss=1", r.way, r.miss, ew);
        end
    endtask

    task automatic test_reset_mid_fill();
        obs_t r; int ew, em, ewb, cyc;
        @(negedge Clock);
        cyc = 0;
        while (!ReqReady && cyc < 20) begin @(negedge Clock); cyc++; end
        ReqValid = 1'b1; ReqSet = 4'd7; ReqHit = 4'b0; ReqWrite = 1'b0;
        @(posedge Clock);
        #1 ReqValid = 1'b0;
        cyc = 0;
        @(negedge Clock);
        while (!FillReq && cyc < 10) begin @(negedge Clock); cyc++; end
        total++;
        if (FillReq !== 1'b1) begin bad++; $display("FAIL rstfill_reach: got %b want 1", FillReq); end
        Reset = 1'b1;
        @(negedge Clock);
        total++;
        if ({WbReq, FillReq, RespValid} !== 3'b000 || ReqReady !== 1'b1) begin
            bad++; $display("FAIL rstfill_abandon: got wb/fill/resp=%b ready=%b want 000 1",
                            {WbReq, FillReq, RespValid}, ReqReady);
        end
        Reset = 1'b0;
        model_reset();
        model_access(7, 4'b0, 1'b0, ew, em, ewb);
        run_txn(7, 4'b0, 1'b0, 0, 0, 1'b0, r);
        total++;
        if (r.way != ew || r.fillway != ew || r.wb != 0) begin
            bad++; $display("FAIL rstfill_set7: got way=%0d fill=%0d wb=%0d want %0d %0d 0", r.way, r.fillway, r.wb, ew, ew);
        end
        model_access(3, 4'b0, 1'b0, ew, em, ewb);
        run_txn(3, 4'b0, 1'b0, 0, 0, 1'b0, r);
        total++;
        if (r.way != ew || r.wb != 0) begin
            bad++; $display("FAIL rstfill_set3_cleared: got way=%0d wb=%0d want %0d 0", r.way, r.wb, ew);
        end
    endtask

    task automatic test_random();
        obs_t r; int ew, em, ewb, s, wd, fd, w;
        logic [3:0] hit; bit wr;
        int vw[$];
        for (int n = 0; n < 300; n++) begin
            s = $urandom_range(0, 3);
            vw.delete();
            for (int k = 0; k < 4; k++) if (mvalid[s][k]) vw.push_back(k);
            hit = 4'b0;
            if (vw.size() > 0 && $urandom_range(0, 2) != 0) begin
                w = vw[$urandom_range(0, vw.size() - 1)];
                hit = 4'(1 << w);
                if ($urandom_range(0, 3) == 0) hit = hit | 4'(1 << vw[$urandom_range(0, vw.size() - 1)]);
            end
            wr = 1'($urandom);
            wd = $urandom_range(0, 3);
            fd = $urandom_range(0, 3);
            model_access(s, hit, wr, ew, em, ewb);
            run_txn(s, hit, wr, wd, fd, 1'($urandom), r);
            total++;
            if (r.to != 0 || r.way != ew || r.miss != em) begin
                bad++; $display("FAIL rand_resp[%0d]: got way=%0d miss=%0d to=%0d want way=%0d miss=%0d",
                                n, r.way, r.miss, r.to, ew, em);
            end
            total++;
            if (r.wb != ewb) begin bad++; $display("FAIL rand_wb[%0d]: got %0d want %0d", n, r.wb, ewb); end
            if (ewb != 0) begin
                total++;
                if (r.wbway != ew || r.wbcyc != wd + 1) begin
                    bad++; $display("FAIL rand_wbway[%0d]: got way=%0d cyc=%0d want way=%0d cyc=%0d",
                                    n, r.wbway, r.wbcyc, ew, wd + 1);
                end
            end
            if (em != 0) begin
                total++;
                if (r.fillway != ew || r.fillcyc != fd + 1) begin
                    bad++; $display("FAIL rand_fill[%0d]: got way=%0d cyc=%0d want way=%0d cyc=%0d",
                                    n, r.fillway, r.fillcyc, ew, fd + 1);
                end
            end else begin
                total++;
                if (r.lat != 2 || r.fillcyc != 0) begin
                    bad++; $display("FAIL rand_hitlat[%0d]: got lat=%0d fillcyc=%0d want 2 0", n, r.lat, r.fillcyc);
                end
            end
            total++;
            if (r.rdy_err != 0) begin bad++; $display("FAIL rand_ready[%0d]: got %0d want 0", n, r.rdy_err); end
        end
    endtask

`ifdef PERF_COUNT_EN
    task automatic test_perf();
        @(negedge Clock);
        total++;
        if (HitCount !== 16'(mhit) || MissCount !== 16'(mmiss) || WbCount !== 16'(mwb)) begin
            bad++; $display("FAIL perf_counts: got h=%0d m=%0d wb=%0d want h=%0d m=%0d wb=%0d",
                            HitCount, MissCount, WbCount, mhit, mmiss, mwb);
        end
        do_reset();
        @(negedge Clock);
        total++;
        if ({HitCount, MissCount, WbCount} !== 48'b0) begin
            bad++; $display("FAIL perf_reset: got h=%0d m=%0d wb=%0d want 0", HitCount, MissCount, WbCount);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_set3();
        test_hit_then_miss();
        test_writeback();
        test_wb_delay();
        test_reset_mid_fill();
        test_random();
`ifdef PERF_COUNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_set_controller.md
Name: cache_set_controller

Overview:
- Per-set replacement and miss sequencer for the 4-way set-associative cache.
- Holds the 6-bit pairwise LRU state plus valid/dirty bits for every set, and accepts one lookup at a time from the tag-compare stage.
- On a hit, updates recency and responds. On a miss, selects a victim, sequences writeback and fill handshakes with the memory side, then responds.
- Sits between the tag array compare logic and the bus interface.

Parameters:
- SETS, 16, number of cache sets (power of 2, >=2)
- SET_BITS, 4, width of set index; must equal log2(SETS)

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- ReqValid  in  1  lookup request present
- ReqReady  out  1  controller can accept a request
- ReqSet  in  SET_BITS  set index of request
- ReqHit  in  4  one-hot way-match vector from tag compare (0 = miss)
- ReqWrite  in  1  request is a write
- WbReq  out  1  writeback request to memory side
- WbWay  out  2  way being written back
- WbAck  in  1  writeback complete
- FillReq  out  1  line fill request
- FillWay  out  2  way being filled
- FillAck  in  1  fill complete
- RespValid  out  1  one-cycle response strobe
- RespWay  out  2  way holding the line
- RespMiss  out  1  response was a miss

Behaviour:
- Reset (synchronous, active-high, overrides everything): state IDLE; all LRU states 6'b000000; all valid/dirty 0; ReqReady=1; WbReq, FillReq, RespValid, RespMiss = 0; WbWay, FillWay, RespWay = 0.
- Reset mid-operation abandons the transaction; WbReq/FillReq are 0 the cycle after Reset is sampled.
- LRU encoding, bits b0..b5 = pairs (0,1),(0,2),(0,3),(1,2),(1,3),(2,3). Bit=1 means the lower way is more recent.
  - Touch way0: b0,b1,b2=1.
  - Touch way1: b0=0; b3,b4=1.
  - Touch way2: b1,b3=0; b5=1.
  - Touch way3: b2,b4,b5=0.
  - LRU way: 0 if {b0,b1,b2}=000; 1 if {b0,b3,b4}=100; 2 if {b1,b3,b5}=110; 3 if {b2,b4,b5}=111.
- FSM states: IDLE, LOOKUP, WB, FILL, RESP.
- IDLE: ReqReady=1. Request accepted when ReqValid && ReqReady; ReqSet, ReqHit and ReqWrite are registered; go to LOOKUP. ReqReady=0 in all other states.
- LOOKUP, hit (ReqHit nonzero; if multiple bits set, lowest index wins):
  - touch hit way; if ReqWrite, set dirty[way].
  - next state RESP, RespMiss=0.
  - RespValid is therefore asserted 2 cycles after acceptance.
- LOOKUP, miss — victim selection:
  - victim = lowest-index invalid way; if all four ways are valid, victim = LRU way.
  - If victim is valid and dirty: WbWay=victim, WbReq=1, go to WB. Otherwise: FillWay=victim, FillReq=1, go to FILL.
- WB: WbReq held high until WbAck sampled 1; then WbReq=0, FillReq=1, go to FILL.
- FILL: FillReq held high until FillAck sampled 1; then valid[victim]=1, dirty[victim]=ReqWrite, touch victim, RespMiss=1, go to RESP.
- Ack handling: acks are only honoured while the matching request is high; WbAck/FillAck at any other time are ignored. An ack present in the same cycle the request is first driven counts.
- RESP: RespValid=1 for exactly one cycle with RespWay and RespMiss valid; return to IDLE. There is no response back-pressure.
- Only the addressed set's state changes; all other sets are untouched.

Optional Feature:
- Macro PERF_COUNT_EN.
- Defined: adds outputs HitCount[15:0] and MissCount[15:0], plus WbCount[15:0].
  - HitCount/MissCount increment on the RESP cycle according to RespMiss.
  - WbCount increments on WbAck acceptance.
  - All three saturate at 16'hFFFF and are cleared by Reset.
- Undefined: these ports and the counter logic do not exist; all other behaviour is identical.

Test Plan:
- Reset, then 4 misses to set 3 with ReqWrite=0 and acks the cycle after the request -> FillWay 0,1,2,3 in order; no WbReq; each RespMiss=1.
- Set 3 full; hit way2; then a miss -> the hit gives RespWay=2, RespMiss=0, 2 cycles after acceptance; the miss victim is way0 (LRU after touching 0,1,2,3,2).
- Write-hit way0 in set 3, then touch 1,2,3, then miss -> WbReq with WbWay=0; FillReq only after WbAck; RespWay=0, RespMiss=1.
- WbAck delayed 5 cycles -> WbReq stays high for all 5 cycles; ReqReady=0 throughout; a stray FillAck during WB is ignored.
- Reset asserted during FILL -> FillReq=0 next cycle; a following miss to the same set picks way0 with all bits cleared.
- With PERF_COUNT_EN, 3 hits + 2 misses (1 dirty) -> HitCount=3, MissCount=2, WbCount=1.
